// File: rtl/median_feed.sv
// median_feed: gathers a 3x3 window of pixels from an upstream valid/ready
// stream. It replays the window as one contiguous burst to an external median
// filter, then waits for the filter's result strobe. The captured median is
// held for a downstream valid/ready consumer. If no result arrives within
// TIMEOUT cycles, a sticky ERR flag is raised and the window is dropped.
//
// Handshakes: a pixel transfers on a rising CLK edge where PIX_VLD and PIX_RDY
// are both 1. A result transfers on an edge where RES_VLD and RES_RDY are both
// 1. Once RES_VLD is raised, RES and RES_VLD stay stable until that transfer.
// Neither ready depends combinationally on the matching valid.
module median_feed #(
  parameter int WIDTH   = 8,
  parameter int NUM     = 9,
  parameter int TIMEOUT = 63
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VLD,
  output logic             PIX_RDY,
  output logic [WIDTH-1:0] DI_MED,
  output logic             DSI_MED,
  input  logic [WIDTH-1:0] DO_MED,
  input  logic             DSO_MED,
  output logic [WIDTH-1:0] RES,
  output logic             RES_VLD,
  input  logic             RES_RDY,
  output logic             BUSY,
  output logic             ERR,
  output logic [1:0]       DBG_STATE
);

  localparam int CW = $clog2(NUM + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(NUM - 1);
  localparam logic [CW-1:0] NUM_IDX   = CW'(NUM);
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ready;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_idx;
  logic [WW-1:0]    r_wait;
  logic [WIDTH-1:0] r_buf [NUM];
  logic [WIDTH-1:0] r_di;
  logic             r_dsi;
  logic [WIDTH-1:0] r_res;
  logic             r_res_vld;
  logic             r_err;

  logic             w_pix_rdy;
  logic             w_accept;
  logic             w_last_pix;
  logic             w_send_done;
  logic             w_timeout;
  logic [WIDTH-1:0] w_first_pix;

  // r_ready keeps PIX_RDY low until the first clock after reset release.
  assign w_pix_rdy   = r_ready && (r_state == ST_COLLECT);
  assign w_accept    = w_pix_rdy && PIX_VLD;
  assign w_last_pix  = w_accept && (r_cnt == LAST_CNT);
  assign w_send_done = (r_state == ST_SEND) && (r_idx == NUM_IDX);
  // A result strobe on the final wait cycle wins over the timeout.
  assign w_timeout   = (r_state == ST_WAIT) && !DSO_MED && (r_wait == LAST_WAIT);
  // For a one-pixel window, slot 0 is written on the same edge the burst starts.
  assign w_first_pix = (r_cnt == '0) ? PIX_IN : r_buf[0];

  assign PIX_RDY   = w_pix_rdy;
  assign DI_MED    = r_di;
  assign DSI_MED   = r_dsi;
  assign RES       = r_res;
  assign RES_VLD   = r_res_vld;
  assign BUSY      = (r_state != ST_COLLECT);
  assign ERR       = r_err;
  assign DBG_STATE = r_state;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= ST_COLLECT;
    else       r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_COLLECT: if (w_last_pix) w_next = ST_SEND;
      ST_SEND:    if (w_send_done) w_next = ST_WAIT;
      ST_WAIT: begin
        if (DSO_MED)        w_next = ST_OUT;
        else if (w_timeout) w_next = ST_COLLECT;
      end
      ST_OUT:     if (RES_RDY) w_next = ST_COLLECT;
      default:    w_next = ST_COLLECT;
    endcase
  end

  // Window buffer: written only while collecting.
  always_ff @(posedge CLK) begin
    if (w_accept) r_buf[r_cnt] <= PIX_IN;
  end

  // Counters, registered burst outputs, result capture and error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ready   <= 1'b0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wait    <= '0;
      r_di      <= '0;
      r_dsi     <= 1'b1;
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      case (r_state)
        ST_COLLECT: begin
          if (w_last_pix) begin
            r_cnt <= '0;
            r_idx <= CW'(1);
            r_dsi <= 1'b0;
            r_di  <= w_first_pix;
          end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (w_send_done) begin
            r_dsi  <= 1'b1;
            r_di   <= '0;
            r_wait <= '0;
          end else begin
            r_di  <= r_buf[r_idx];
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_WAIT: begin
          if (DSO_MED) begin
            r_res     <= DO_MED;
            r_res_vld <= 1'b1;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_OUT: begin
          if (RES_RDY) r_res_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_median_feed.sv
// Bench for median_feed: randomized windows, a queue-based reference model,
// a per-cycle compare process and directed scenarios with literal expectations.
module tb_median_feed;

  localparam int W       = 8;
  localparam int NUM     = 9;
  localparam int TIMEOUT = 63;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [W-1:0] PIX_IN = '0;
  logic         PIX_VLD = 1'b0;
  logic         PIX_RDY;
  logic [W-1:0] DI_MED;
  logic         DSI_MED;
  logic [W-1:0] DO_MED = '0;
  logic         DSO_MED = 1'b0;
  logic [W-1:0] RES;
  logic         RES_VLD;
  logic         RES_RDY = 1'b0;
  logic         BUSY;
  logic         ERR;
  logic [1:0]   DBG_STATE;

  median_feed #(.WIDTH(W), .NUM(NUM), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST), .PIX_IN(PIX_IN), .PIX_VLD(PIX_VLD), .PIX_RDY(PIX_RDY),
    .DI_MED(DI_MED), .DSI_MED(DSI_MED), .DO_MED(DO_MED), .DSO_MED(DSO_MED),
    .RES(RES), .RES_VLD(RES_VLD), .RES_RDY(RES_RDY), .BUSY(BUSY), .ERR(ERR),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_COLLECT, M_SEND, M_WAIT, M_OUT} mmode_t;
  mmode_t       m_mode;
  logic [W-1:0] win_q[$];
  logic [W-1:0] exp_q[$];
  int           m_wait;
  logic [W-1:0] m_di;
  logic [W-1:0] m_res;
  bit           m_dsi, m_vld, m_err, m_rdy;

  task automatic model_reset();
    win_q.delete();
    exp_q.delete();
    m_mode = M_COLLECT;
    m_wait = 0;
    m_di   = '0;
    m_dsi  = 1'b1;
    m_res  = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    m_rdy  = 1'b0;
  endtask

  always @(posedge CLK) begin
    if (nRST) begin
      case (m_mode)
        M_COLLECT: if (m_rdy && PIX_VLD) begin
          win_q.push_back(PIX_IN);
          if (win_q.size() == NUM) begin
            exp_q = win_q;
            win_q.delete();
            m_mode = M_SEND;
            m_dsi  = 1'b0;
            m_di   = exp_q.pop_front();
          end
        end
        M_SEND: begin
          if (exp_q.size() == 0) begin
            m_dsi  = 1'b1;
            m_di   = '0;
            m_mode = M_WAIT;
            m_wait = 0;
          end else begin
            m_di = exp_q.pop_front();
          end
        end
        M_WAIT: begin
          if (DSO_MED) begin
            m_res  = DO_MED;
            m_vld  = 1'b1;
            m_mode = M_OUT;
          end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
              m_err  = 1'b1;
              m_mode = M_COLLECT;
            end
          end
        end
        M_OUT: if (RES_RDY) begin
          m_vld  = 1'b0;
          m_mode = M_COLLECT;
        end
        default: ;
      endcase
      m_rdy = 1'b1;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge CLK) begin
    check("pix_rdy", PIX_RDY, (m_rdy && m_mode == M_COLLECT));
    check("busy",    BUSY,    (m_mode != M_COLLECT));
    check("dsi_med", DSI_MED, m_dsi);
    check("di_med",  DI_MED,  m_di);
    check("res_vld", RES_VLD, m_vld);
    check("res",     RES,     m_res);
    check("err",     ERR,     m_err);
  end

  // Burst capture for order checks.
  logic [W-1:0] got_q[$];
  always @(negedge CLK) begin
    if (nRST && DSI_MED === 1'b0) got_q.push_back(DI_MED);
  end

  // ---------------- driver tasks ----------------
  logic [W-1:0] win_px [NUM];
  logic [W-1:0] last_res;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] median_of();
    logic [W-1:0] q[$];
    foreach (win_px[i]) q.push_back(win_px[i]);
    q.sort();
    return q[NUM/2];
  endfunction

  task automatic rand_window();
    foreach (win_px[i]) win_px[i] = W'($urandom);
  endtask

  // Feed the window; returns just after the edge accepting the last pixel.
  task automatic send_window(input int gap_min, input int gap_max, input bit spurious);
    bit rdy;
    int guard;
    int g;
    for (int i = 0; i < NUM; i++) begin
      PIX_IN  = win_px[i];
      PIX_VLD = 1'b1;
      guard = 0;
      do begin
        rdy = PIX_RDY;
        step();
        guard++;
      end while (!rdy && guard < 100);
      if (!rdy) check("accept_bound", 0, 1);
      PIX_VLD = 1'b0;
      PIX_IN  = W'($urandom);
      if (i < NUM - 1) begin
        g = $urandom_range(gap_max, gap_min);
        for (int k = 0; k < g; k++) begin
          DSO_MED = spurious;
          DO_MED  = W'($urandom);
          step();
        end
        DSO_MED = 1'b0;
      end
    end
  endtask

  task automatic wait_burst_end();
    int n = 0;
    while (DSI_MED !== 1'b0 && n < 200) begin step(); n++; end
    while (DSI_MED !== 1'b1 && n < 200) begin step(); n++; end
    if (n >= 200) check("burst_bound", 0, 1);
  endtask

  task automatic check_burst(input string name);
    check({name, "_len"}, got_q.size(), NUM);
    for (int i = 0; i < NUM && i < got_q.size(); i++) check(name, got_q[i], win_px[i]);
  endtask

  task automatic respond(input int delay, input logic [W-1:0] value);
    repeat (delay) step();
    DSO_MED = 1'b1;
    DO_MED  = value;
    step();
    DSO_MED = 1'b0;
    DO_MED  = W'($urandom);
  endtask

  task automatic release_result(input int delay);
    repeat (delay) step();
    RES_RDY = 1'b1;
    step();
    RES_RDY = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [W-1:0] med;
    model_reset();
    nRST = 1'b0;
    repeat (3) step();
    check("rst_pix_rdy", PIX_RDY, 0);
    check("rst_busy",    BUSY,    0);
    check("rst_dsi",     DSI_MED, 1);
    check("rst_di",      DI_MED,  0);
    check("rst_res",     RES,     0);
    check("rst_res_vld", RES_VLD, 0);
    check("rst_err",     ERR,     0);
    check("rst_state",   DBG_STATE, 0);
    nRST = 1'b1;
    step();
    check("rdy_after_rst", PIX_RDY, 1);

    // 10..90 back to back, filter returns 50.
    for (int i = 0; i < NUM; i++) win_px[i] = W'(10 * (i + 1));
    got_q.delete();
    send_window(0, 0, 1'b0);
    wait_burst_end();
    check("b1_len", got_q.size(), 9);
    for (int i = 0; i < 9 && i < got_q.size(); i++) check("b1_px", got_q[i], 10 * (i + 1));
    respond(3, 8'd50);
    check("b1_res", RES, 50);
    check("b1_res_vld", RES_VLD, 1);
    release_result(2);
    last_res = 8'd50;

    // Valid toggling every other cycle.
    rand_window();
    got_q.delete();
    send_window(1, 1, 1'b0);
    wait_burst_end();
    check_burst("toggle_px");
    med = median_of();
    respond(5, med);
    check("toggle_res", RES, med);
    release_result(1);
    last_res = med;

    // Spurious strobes in COLLECT and SEND, then no result: timeout.
    rand_window();
    got_q.delete();
    send_window(1, 2, 1'b1);
    DSO_MED = 1'b1;
    DO_MED  = 8'hAA;
    step();
    DSO_MED = 1'b0;
    check("spur_busy", BUSY, 1);
    wait_burst_end();
    check_burst("spur_px");
    check("spur_res_vld", RES_VLD, 0);
    n = 0;
    while (ERR !== 1'b1 && n < 200) begin step(); n++; end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_res_vld", RES_VLD, 0);
    check("timeout_res", RES, last_res);
    check("timeout_pix_rdy", PIX_RDY, 1);

    // Downstream stalls for 20 cycles while upstream keeps offering.
    rand_window();
    got_q.delete();
    send_window(0, 1, 1'b0);
    wait_burst_end();
    check_burst("stall_px");
    med = median_of();
    respond(1, med);
    PIX_VLD = 1'b1;
    PIX_IN  = 8'h33;
    repeat (20) step();
    check("stall_res_vld", RES_VLD, 1);
    check("stall_res", RES, med);
    check("stall_pix_rdy", PIX_RDY, 0);
    check("stall_dsi", DSI_MED, 1);
    RES_RDY = 1'b1;
    step();
    RES_RDY = 1'b0;
    PIX_VLD = 1'b0;
    check("stall_busy_after", BUSY, 0);
    check("stall_rdy_after", PIX_RDY, 1);
    last_res = med;

    // Reset during the 5th SEND cycle.
    rand_window();
    got_q.delete();
    send_window(0, 0, 1'b0);
    repeat (4) step();
    check("pre_rst_dsi", DSI_MED, 0);
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    check("mid_rst_dsi", DSI_MED, 1);
    check("mid_rst_di", DI_MED, 0);
    check("mid_rst_pix_rdy", PIX_RDY, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_res_vld", RES_VLD, 0);
    check("mid_rst_res", RES, 0);
    check("mid_rst_err", ERR, 0);
    repeat (2) step();
    nRST = 1'b1;
    step();
    rand_window();
    got_q.delete();
    send_window(0, 2, 1'b0);
    wait_burst_end();
    check_burst("post_rst_px");
    med = median_of();
    respond(2, med);
    check("post_rst_res", RES, med);
    release_result(0);

    // Random windows; the first delivers its result on the last legal wait cycle.
    for (int w = 0; w < 6; w++) begin
      rand_window();
      got_q.delete();
      send_window(0, 2, 1'($urandom_range(1, 0)));
      wait_burst_end();
      check_burst("rand_px");
      med = median_of();
      respond((w == 0) ? TIMEOUT - 1 : int'($urandom_range(8, 0)), med);
      check("rand_res", RES, med);
      check("rand_res_vld", RES_VLD, 1);
      release_result($urandom_range(4, 0));
    end
    check("final_err", ERR, 0);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_feed.md
MEDIAN_FEED -- requirements
Module: median_feed

Interface
REQ-001 Parameter WIDTH, default 8, pixel width in bits.
REQ-002 Parameter NUM, default 9, pixels per window (3x3).
REQ-003 Parameter TIMEOUT, default 63, maximum result-wait cycles.
REQ-004 CLK  input  1  clock; all state changes on its rising edge.
REQ-005 nRST  input  1  reset, asynchronous, active-low.
REQ-006 PIX_IN  input  WIDTH  upstream pixel data.
REQ-007 PIX_VLD  input  1  upstream pixel valid.
REQ-008 PIX_RDY  output  1  block accepts a pixel this cycle.
REQ-009 DI_MED  output  WIDTH  pixel stream to the median filter DI.
REQ-010 DSI_MED  output  1  frame strobe to the median filter DSI; high = no burst, low = burst pixel.
REQ-011 DO_MED  input  WIDTH  median result from the filter DO.
REQ-012 DSO_MED  input  1  one-cycle result strobe from the filter DSO.
REQ-013 RES  output  WIDTH  captured median result.
REQ-014 RES_VLD  output  1  RES valid.
REQ-015 RES_RDY  input  1  downstream accepts RES.
REQ-016 BUSY  output  1  high in every state except COLLECT.
REQ-017 ERR  output  1  sticky timeout flag.

Function
REQ-018 FSM states COLLECT, SEND, WAIT, OUT; one-hot or encoded, no other reachable state.
REQ-019 COLLECT: PIX_RDY=1; each cycle with PIX_VLD=1 stores PIX_IN in buffer[cnt], cnt increments 0..NUM-1.
REQ-020 COLLECT: PIX_VLD=0 cycles do not advance cnt; gaps of any length are legal.
REQ-021 COLLECT->SEND on the edge accepting pixel NUM-1; cnt clears; PIX_RDY=0 in all states but COLLECT.
REQ-022 SEND: DI_MED, DSI_MED registered; DSI_MED=0 for exactly NUM consecutive cycles, DI_MED=buffer[0..NUM-1] in order, first pixel in the cycle DSI_MED first goes low.
REQ-023 DSI_MED first goes low the cycle after the accepting edge of pixel NUM-1 (1-cycle latency).
REQ-024 SEND->WAIT after pixel NUM-1 is driven; DSI_MED returns to 1 and DI_MED to 0 next cycle.
REQ-025 DSI_MED SHALL be 1 in all states except SEND.
REQ-026 WAIT: wait counter counts cycles from entry; DSO_MED=1 captures DO_MED into RES, sets RES_VLD, goes OUT.
REQ-027 WAIT: if the wait counter reaches TIMEOUT with no DSO_MED, set ERR, discard the window, return to COLLECT; RES, RES_VLD unchanged.
REQ-028 DSO_MED=1 in the same cycle as timeout expiry counts as a result, not a timeout.
REQ-029 DSO_MED pulses in COLLECT, SEND or OUT are ignored.
REQ-030 OUT: RES, RES_VLD held stable until RES_RDY=1; on that edge RES_VLD clears, state -> COLLECT.
REQ-031 Between consecutive bursts DSI_MED stays high at least 2 cycles (guaranteed by WAIT+OUT minimum residence).
REQ-032 ERR stays 1 until reset; further windows process normally.
REQ-033 Buffer writes only in COLLECT; buffer contents are stable throughout SEND.

Reset
REQ-034 nRST=0 asynchronously forces: state COLLECT, cnt=0, wait counter=0, DI_MED=0, DSI_MED=1, RES=0, RES_VLD=0, ERR=0.
REQ-035 Under reset PIX_RDY=0, BUSY=0; PIX_RDY=1 from the first clock after nRST deasserts.
REQ-036 Reset mid-SEND drives DSI_MED to 1 immediately; the partial burst is abandoned; no result is produced.

Verification
REQ-037 9 pixels 10..90 back-to-back, filter model returns 50 after DSO_MED -> DSI_MED low exactly 9 cycles with DI_MED 10,20..90, RES=50, RES_VLD=1.
REQ-038 Pixels with PIX_VLD toggling every other cycle -> same 9-cycle contiguous burst, order preserved.
REQ-039 No DSO_MED after burst -> ERR=1 exactly TIMEOUT cycles after WAIT entry, RES_VLD stays 0, PIX_RDY=1 next cycle.
REQ-040 RES_RDY held 0 for 20 cycles -> RES, RES_VLD stable, PIX_RDY=0, no new burst; RES_RDY=1 -> COLLECT next cycle.
REQ-041 nRST pulsed during 5th SEND cycle -> DSI_MED=1 asynchronously, all outputs at reset values, fresh window then processed correctly.
REQ-042 Spurious DSO_MED during COLLECT and SEND -> no RES_VLD, no state change.
